// File: rtl/gb_clk_enable.sv
// rtl/gb_clk_enable.sv - PLL-lock reset sequencer and system-clock divider producing single-cycle CPU/PPU enables.
module gb_clk_enable #(
  parameter int DIV       = 16,
  parameter int LOCK_WAIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic speed_req,
  input  logic pause,
  output logic reset_out,
  output logic ce,
  output logic ce_n,
  output logic ce_2x,
  output logic ce_cpu,
  output logic speed_active,
  output logic lost_lock
);

  localparam int DW = $clog2(DIV);
  localparam int LW = $clog2(LOCK_WAIT);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(DIV / 2 - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t        state;
  logic          locked_m;
  logic          locked_s;
  logic [LW-1:0] lock_cnt;
  logic [DW-1:0] div_cnt;
  logic          run_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= pll_locked;
      locked_s <= locked_m;
    end
  end

  // Loss of lock overrides every other transition and clears all progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_HOLD;
      reset_out    <= 1'b1;
      lock_cnt     <= '0;
      div_cnt      <= '0;
      speed_active <= 1'b0;
      lost_lock    <= 1'b0;
    end else if (!locked_s) begin
      state        <= ST_HOLD;
      reset_out    <= 1'b1;
      lock_cnt     <= '0;
      div_cnt      <= '0;
      speed_active <= 1'b0;
      if (state == ST_RUN) begin
        lost_lock <= 1'b1;
      end
    end else begin
      case (state)
        ST_HOLD: begin
          state        <= ST_WAIT;
          reset_out    <= 1'b1;
          lock_cnt     <= '0;
          div_cnt      <= '0;
          speed_active <= 1'b0;
        end
        ST_WAIT: begin
          speed_active <= 1'b0;
          div_cnt      <= '0;
          if (lock_cnt == LOCK_LAST) begin
            state     <= ST_RUN;
            reset_out <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        ST_RUN: begin
          // DIV is a power of two, so the natural wrap gives modulo-DIV counting.
          div_cnt <= div_cnt + DW'(1);
          if (div_cnt == DIV_LAST) begin
            speed_active <= speed_req;
          end
        end
        default: begin
          state     <= ST_HOLD;
          reset_out <= 1'b1;
        end
      endcase
    end
  end

  assign run_en = (state == ST_RUN) && !pause;
  assign ce     = run_en && (div_cnt == DIV_LAST);
  assign ce_n   = run_en && (div_cnt == DIV_HALF);
  assign ce_2x  = ce | ce_n;
  assign ce_cpu = speed_active ? ce_2x : ce;

endmodule

// File: tb/tb_gb_clk_enable.sv
// tb/tb_gb_clk_enable.sv - directed bench for gb_clk_enable with DIV=16, LOCK_WAIT=8.
module tb_gb_clk_enable;

  logic clk = 1'b0;
  logic rst;
  logic pll_locked;
  logic speed_req;
  logic pause;
  logic reset_out;
  logic ce;
  logic ce_n;
  logic ce_2x;
  logic ce_cpu;
  logic speed_active;
  logic lost_lock;
  logic [6:0] outs;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int run_base = 0;

  always #5 clk = ~clk;

  gb_clk_enable #(.DIV(16), .LOCK_WAIT(8)) dut (
    .clk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .speed_req(speed_req),
    .pause(pause),
    .reset_out(reset_out),
    .ce(ce),
    .ce_n(ce_n),
    .ce_2x(ce_2x),
    .ce_cpu(ce_cpu),
    .speed_active(speed_active),
    .lost_lock(lost_lock)
  );

  assign outs = {reset_out, ce, ce_n, ce_2x, ce_cpu, speed_active, lost_lock};

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic int phase();
    return (cyc - run_base) % 16;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    pll_locked = 1'b0;
    speed_req = 1'b0;
    pause = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (outs !== 7'b1000000) $display("FAIL reset_state: got %b want %b", outs, 7'b1000000);
    else passed++;
  endtask

  task automatic test_lockup;
    int t0;
    logic run;
    int ph;
    logic [6:0] exp;
    rst = 1'b0;
    pll_locked = 1'b1;
    t0 = cyc;
    for (int c = 1; c <= 60; c++) begin
      tick();
      run = (c >= 11);
      ph = run ? (c - 11) % 16 : 0;
      exp = {!run, run && ph == 15, run && ph == 7, run && (ph == 15 || ph == 7),
             run && ph == 15, 1'b0, 1'b0};
      total++;
      if (outs !== exp) $display("FAIL lockup c=%0d: got %b want %b", c, outs, exp);
      else passed++;
    end
    run_base = t0 + 11;
  endtask

  task automatic test_speed_switch;
    logic spd;
    int last;
    int ph;
    logic ec;
    logic en;
    logic [6:0] exp;
    spd = 1'b0;
    last = -1;
    for (int i = 0; i < 16 && phase() != 5; i++) tick();
    speed_req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 40) speed_req = 1'b0;
      ph = phase();
      ec = (ph == 15);
      en = (ph == 7);
      exp = {1'b0, ec, en, ec | en, spd ? (ec | en) : ec, spd, 1'b0};
      total++;
      if (outs !== exp) $display("FAIL speed i=%0d ph=%0d: got %b want %b", i, ph, outs, exp);
      else passed++;
      if (ce_cpu === 1'b1) begin
        if (spd && last >= 0) begin
          total++;
          if (cyc - last != 8) $display("FAIL speed_gap i=%0d: got %0d want 8", i, cyc - last);
          else passed++;
        end
        last = cyc;
      end
      if (ph == 15) spd = speed_req;
      tick();
    end
  endtask

  task automatic test_pause;
    logic found;
    pause = 1'b1;
    for (int i = 0; i < 40; i++) begin
      total++;
      if ({reset_out, ce, ce_n, ce_2x, ce_cpu} !== 5'b00000)
        $display("FAIL pause_gate i=%0d: got %b want 00000", i, {reset_out, ce, ce_n, ce_2x, ce_cpu});
      else passed++;
      tick();
    end
    pause = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ce === 1'b1) found = 1'b1;
      else tick();
    end
    total++;
    if (!found || phase() != 15)
      $display("FAIL pause_phase: got found=%0b phase=%0d want found=1 phase=15", found, phase());
    else passed++;
  endtask

  task automatic test_lock_loss;
    int t0;
    pll_locked = 1'b0;
    tick();
    tick();
    total++;
    if (reset_out !== 1'b0) $display("FAIL lockloss_early: got reset_out=%b want 0", reset_out);
    else passed++;
    tick();
    total++;
    if (outs !== 7'b1000001) $display("FAIL lockloss_hold: got %b want %b", outs, 7'b1000001);
    else passed++;
    pll_locked = 1'b1;
    t0 = cyc;
    for (int c = 1; c <= 12; c++) begin
      tick();
      total++;
      if ({reset_out, lost_lock} !== {c < 11, 1'b1})
        $display("FAIL relock c=%0d: got %b want %b", c, {reset_out, lost_lock}, {c < 11, 1'b1});
      else passed++;
    end
    run_base = t0 + 11;
  endtask

  task automatic test_async_reset;
    logic seen;
    seen = 1'b0;
    speed_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (phase() == 15) seen = 1'b1;
      tick();
      if (seen && phase() == 7) break;
    end
    total++;
    if (outs !== 7'b0011111) $display("FAIL pre_rst: got %b want %b", outs, 7'b0011111);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if (outs !== 7'b1000000) $display("FAIL async_rst: got %b want %b", outs, 7'b1000000);
    else passed++;
    tick();
    tick();
    speed_req = 1'b0;
  endtask

  task automatic test_lock_glitch;
    logic [2:0] exp;
    rst = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      if (c == 5) pll_locked = 1'b0;
      if (c == 6) pll_locked = 1'b1;
      exp = {c < 17, 1'b0, c == 32};
      total++;
      if ({reset_out, lost_lock, ce} !== exp)
        $display("FAIL glitch c=%0d: got %b want %b", c, {reset_out, lost_lock, ce}, exp);
      else passed++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lockup();
    test_speed_switch();
    test_pause();
    test_lock_loss();
    test_async_reset();
    test_lock_glitch();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
